// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind uart_receiver: show-ahead valid/ready read port, level/full/empty status.
// Optional sticky drop flag when UART_RX_FIFO_OVERFLOW_EN is defined.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        wr_data_i,
    input  logic              wr_valid_i,
    output logic [7:0]        rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [ADDR_W:0]   level_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o,
    input  logic              ovf_clr_i
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              push, pop;

    assign full_o     = (level_q == DEPTH_L);
    assign empty_o    = (level_q == '0);
    assign rd_valid_o = !empty_o;
    assign level_o    = level_q;
    assign rd_data_o  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same edge, so a full FIFO still accepts a push.
    assign pop  = rd_valid_o && rd_ready_i;
    assign push = wr_valid_i && (!full_o || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        if (push && !pop)      level_d = level_q + (ADDR_W+1)'(1);
        else if (pop && !push) level_d = level_q - (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

`ifdef UART_RX_FIFO_OVERFLOW_EN
    logic ovf_q, ovf_d, drop;

    assign drop = wr_valid_i && !push;

    always_comb begin
        ovf_d = ovf_q;
        if (drop)           ovf_d = 1'b1;
        else if (ovf_clr_i) ovf_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign overflow_o = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr_i;
    assign overflow_o     = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte buffer directly downstream of `uart_receiver`. Captures each received byte on the receiver's one-cycle `received_byte` strobe and holds bytes in a circular buffer until the consumer pops them through a valid/ready read port. The buffer decouples the bursty serial input from a slower or stalled consumer and reports fill level, full/empty status and lost-byte overflow.

## Interface

Parameters:
- `DEPTH`, default 16: number of byte entries. Must be a power of two and ≥ 2.
- `ADDR_W`, default `$clog2(DEPTH)`: pointer width. Derived; not overridden.

Ports:
- `clk` in 1: single clock for all state.
- `rst` in 1: asynchronous, active-high reset.
- `wr_data` in 8: byte from `uart_receiver.data_out`.
- `wr_valid` in 1: push strobe from `uart_receiver.received_byte`; one cycle per byte.
- `rd_data` out 8: head-of-queue byte. Valid only while `rd_valid` is 1.
- `rd_valid` out 1: queue non-empty.
- `rd_ready` in 1: consumer pops the head on any edge where `rd_valid && rd_ready`.
- `level` out ADDR_W+1: number of stored bytes, 0..DEPTH.
- `full` out 1: `level == DEPTH`.
- `empty` out 1: `level == 0`.
- `overflow` out 1: sticky flag indicating a byte was dropped.
- `ovf_clr` in 1: clears `overflow`.

## Operation

Storage and pointers:
- Storage is a `DEPTH` x 8 register array.
- `wr_ptr` and `rd_ptr` are ADDR_W bits wide and wrap modulo DEPTH with natural overflow.
- `level` is a separate ADDR_W+1-bit counter.

Push, pop and level:
- Push is accepted when `wr_valid && (!full || pop)`. It writes `mem[wr_ptr]` and increments `wr_ptr`.
- Pop occurs when `rd_valid && rd_ready`. It increments `rd_ptr`.
- Level update: +1 on push only, −1 on pop only, unchanged on push+pop or on neither.

Boundary cases:
- Full with push and pop in the same cycle: both are performed and `level` stays at DEPTH.
- Empty with `wr_valid` and `rd_ready` in the same cycle: the push is performed, the pop is ignored, and `level` becomes 1.
- Full with `wr_valid` and no pop: the byte is dropped. Pointers, storage and `level` are unchanged. Overflow handling is described under Configuration.

Read data:
- `rd_data` is driven combinationally as `mem[rd_ptr]` (show-ahead).
- `rd_data` does not change while `rd_valid && !rd_ready`.
- Pointer wrap from DEPTH−1 to 0 is seamless: byte order is preserved across the wrap.

## Timing

- Reset values: `level` 0, `empty` 1, `full` 0, `rd_valid` 0, `overflow` 0, both pointers 0. `rd_data` is don't-care. Storage is not cleared.
- Write-to-read latency is 1 cycle. After the edge that samples `wr_valid` into an empty buffer, `rd_valid` = 1 and `rd_data` = that byte.
- A pop takes effect at the sampling edge. The next byte, or `empty` = 1, is visible immediately after that edge.
- `full`, `empty`, `rd_valid` and `level` are all updated at the same edge, with no extra lag.
- Reset asserted mid-operation clears all state asynchronously. Any byte presented in the same cycle is lost.
- Back-to-back `wr_valid` on consecutive cycles must be accepted: one push per cycle.

## Configuration

Macro: `UART_RX_FIFO_OVERFLOW_EN`.
- Defined:
  - `overflow` is set on the edge where a byte is dropped and stays set until an edge with `ovf_clr` = 1.
  - If a drop and `ovf_clr` occur on the same edge, set wins and `overflow` stays 1.
  - `ovf_clr` has no effect on data or `level`.
- Not defined:
  - `overflow` is tied to 0 and `ovf_clr` is ignored.
  - Drop-on-full behaviour is unchanged.

## Test plan

- **Reset then single push:** release `rst`, then pulse `wr_valid` with `wr_data` = 0x35. Next cycle: `rd_valid` = 1, `rd_data` = 0x35, `level` = 1, `empty` = 0. Pop with `rd_ready` → `empty` = 1, `level` = 0.
- **Ordering with stall:** push 0x35, then 0xCE, with `rd_ready` held at 0. `rd_data` stays 0x35 for ≥ 3 cycles. Assert `rd_ready` → reads 0x35 then 0xCE, then `empty`.
- **Fill and overflow (DEPTH = 16, macro defined):** push 0x00..0x0F → `full` = 1, `level` = 16. Push 0xAA → `overflow` = 1, `level` = 16. Drain → reads 0x00..0x0F in order, 0xAA absent. Pulse `ovf_clr` → `overflow` = 0.
- **Simultaneous push and pop:**
  - While full, push 0x55 with `rd_ready` = 1 → `level` stays 16, `overflow` stays 0. The last byte read after draining is 0x55.
  - While empty, push 0x11 with `rd_ready` = 1 → `level` = 1, `rd_data` = 0x11.
- **Wrap-around:** 40 push/pop pairs with values 0x80+n at `level` ≤ 3 → every byte is read back in order across pointer wraps.
- **Reset mid-operation:** with `level` = 5, assert `rst` asynchronously between edges → `level` = 0, `empty` = 1, `overflow` = 0 before the next edge.
